des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key-schedule generator. It accepts a 64-bit key and emits the 16 round subkeys K1..K16 for encryption, or K16..K1 for decryption, one per accepted handshake. Each 48-bit subkey is XORed downstream with the expanded right half, and the result feeds the eight S-boxes. Because subkeys are generated iteratively, the full 16×48 key table is never stored.

## Interface
No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new schedule; sampled only in IDLE.
- decrypt  in  1  0 = K1→K16 order, 1 = K16→K1; sampled with start.
- key  in  [64:1]  DES key. FIPS bit n (1 = leftmost) is key[65-n]. Parity bits (FIPS 8,16,…,64) are ignored.
- subkey  out  [48:1]  current subkey. FIPS bit n is subkey[49-n]. Forced to 0 when subkey_valid = 0.
- subkey_valid  out  1  subkey holds a valid subkey.
- subkey_ready  in  1  consumer accepts subkey when valid & ready.
- round  out  [4:1]  sequence position 0..15 of the presented subkey; 0 in IDLE.
- busy  out  1  1 in RUN.
- done  out  1  one-cycle pulse in the cycle after the 16th subkey is accepted.

## Operation
- Datapath:
  - 56-bit register CD, holding C in the upper 28 bits and D in the lower 28.
  - PC-1 and PC-2 are pure wiring, as defined in FIPS 46-3.
  - subkey = PC2(CD) while RUN.
- Shift table, encryption, position p = 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Both halves rotate left.
- Shift table, decryption, position p = 0..15: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Both halves rotate right.
- FSM states are IDLE and RUN.
  - IDLE → RUN on start = 1:
    - encryption: CD ← rotl1(PC1(key));
    - decryption: CD ← PC1(key), since C16D16 = C0D0;
    - round ← 0; decrypt is latched into mode_r.
  - RUN with valid & ready and round < 15: round ← round + 1, and CD is rotated by the shift-table entry for the new position in mode_r direction.
  - RUN with valid & ready and round = 15: go to IDLE, done ← 1 for one cycle, CD ← 0, round ← 0.
  - RUN without ready: hold CD, round and subkey stable. There is no timeout.
- start in RUN is ignored and does not restart. key and decrypt are don't-care after the start cycle.
- start in the same cycle as the final handshake is ignored, because the FSM is still in RUN. A new start is accepted from the following cycle, which is also the done cycle.
- Reset values: state IDLE, CD = 0, round = 0, mode_r = 0, subkey = 0, subkey_valid = 0, busy = 0, done = 0.
- rst mid-schedule aborts immediately to the reset values. No done pulse is produced.

## Timing
- Latency: start sampled at edge t means subkey_valid = 1 with the first subkey from edge t+1.
- Throughput: one subkey per cycle while subkey_ready = 1. A full schedule is 16 cycles.
  - With ready tied high: start at edge t gives done = 1 in cycle t+17 and busy = 1 in cycles t+1..t+16.
- subkey_valid equals busy.
- All outputs are registered or pure wiring off registers. There is no combinational path from start, key or subkey_ready to any output.

## Test plan
- Known-answer encryption. Stimulus: key = 0x133457799BBCDFF1, decrypt = 0, ready = 1. Required: K1 = 0x1B02EFFC7072 at round 0 and K16 = 0xCB3D8B0E17F5 at round 15; done pulses exactly one cycle later; busy is high for exactly 16 cycles.
- Known-answer decryption. Same key with decrypt = 1. Required: first subkey = 0xCB3D8B0E17F5 and last = 0x1B02EFFC7072. The full sequence is the exact reverse of the encryption run against a reference model.
- Backpressure. Toggle subkey_ready pseudo-randomly, including 10-cycle stalls. Required: subkey and round stay stable while not ready; 16 distinct handshakes occur; values match the ready = 1 run.
- Parity independence. Run key = 0x0000000000000000 and key = 0x0101010101010101. Required: all 16 subkeys = 0 in both runs. Then run key = 0xFFFFFFFFFFFFFFFF. Required: all subkeys = 0xFFFFFFFFFFFF.
- Ignored start. Assert start with a different key at round 5, and also on the final-handshake cycle. Required: the sequence is unaffected and no restart occurs. A start in the done cycle is accepted and produces a new schedule.
- Reset mid-run. Assert rst at round 7. Required: on the next edge all outputs are 0, state is IDLE, and there is no done pulse. A following start produces a correct full schedule.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Handshake bundle between the DES key-schedule generator and its consumer.
// Handshake: a subkey transfers on a rising clk edge where subkey_valid & subkey_ready are both 1;
// while subkey_valid is 1 and subkey_ready is 0, subkey and round are held stable.
interface des_key_schedule_if;
  logic        start;
  logic        decrypt;
  logic [64:1] key;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [4:1]  round;
  logic        busy;
  logic        done;
  logic        state_dbg;

  modport master (
    output start, decrypt, key, subkey_ready,
    input  subkey, subkey_valid, round, busy, done, state_dbg
  );

  modport slave (
    input  start, decrypt, key, subkey_ready,
    output subkey, subkey_valid, round, busy, done, state_dbg
  );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit subkey per handshake, K1..K16 or K16..K1.
// Only the 56-bit C/D register is kept; each subkey is PC-2 wiring off it.
module des_key_schedule (
  input  logic                       clk,
  input  logic                       rst,
  des_key_schedule_if.slave          bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // FIPS bit n of a [W:1] vector sits at index W+1-n.
  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(56 - i)] = k[7'(65 - PC1_TBL[i])];
    end
    return r;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(48 - i)] = cd[6'(57 - PC2_TBL[i])];
    end
    return r;
  endfunction

  function automatic logic [28:1] rot28(input logic [28:1] x, input logic [1:0] n,
                                        input logic right);
    logic [28:1] r;
    case (n)
      2'd1:    r = right ? {x[1], x[28:2]}   : {x[27:1], x[28]};
      2'd2:    r = right ? {x[2:1], x[28:3]} : {x[26:1], x[28:27]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [56:1] rot_cd(input logic [56:1] cd, input logic [1:0] n,
                                         input logic right);
    return {rot28(cd[56:29], n, right), rot28(cd[28:1], n, right)};
  endfunction

  // Rotation applied when stepping onto position pos; decryption walks the
  // encryption table backwards, so its entry 0 is never used while running.
  function automatic logic [1:0] shift_amt(input logic [3:0] pos, input logic dec);
    logic [1:0] n;
    if (pos == 4'd0)                                       n = dec ? 2'd0 : 2'd1;
    else if (pos == 4'd1 || pos == 4'd8 || pos == 4'd15)   n = 2'd1;
    else                                                   n = 2'd2;
    return n;
  endfunction

  state_e      state_q, state_d;
  logic [56:1] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [3:0]  round_nxt;

  assign round_nxt = round_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          // C16D16 equals C0D0, so decryption starts from the unrotated PC-1.
          cd_d    = bus.decrypt ? pc1(bus.key) : rot_cd(pc1(bus.key), 2'd1, 1'b0);
          round_d = 4'd0;
          mode_d  = bus.decrypt;
        end
      end
      RUN: begin
        if (bus.subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cd_d    = '0;
            round_d = 4'd0;
          end else begin
            round_d = round_nxt;
            cd_d    = rot_cd(cd_q, shift_amt(round_nxt, mode_q), mode_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign bus.subkey       = (state_q == RUN) ? pc2(cd_q) : '0;
  assign bus.subkey_valid = (state_q == RUN);
  assign bus.busy         = (state_q == RUN);
  assign bus.round        = round_q;
  assign bus.done         = done_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer vectors, backpressure,
// ignored starts, back-to-back starts and mid-run reset.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  des_key_schedule_if bus();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Reference: subkey at sequence position pos, from C0D0 rotated by the
  // cumulative encryption shift; decryption is the reversed encryption order.
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input logic dec,
                                               input int pos);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    int idx, tot;
    cd = '0;
    r  = '0;
    for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - M_PC1[i]];
    idx = dec ? 15 - pos : pos;
    tot = 0;
    for (int i = 0; i <= idx; i++) tot += M_SH[i];
    c = cd[55:28];
    d = cd[27:0];
    for (int j = 0; j < tot % 28; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - M_PC2[i]];
    return r;
  endfunction

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [47:0] last;
    int          stall;
    bit          glitch;
  } vec_t;

  vec_t        vecs [8];
  logic [47:0] got [16];
  logic [47:0] enc_ref [16];
  int          n_got;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts a schedule from the current cycle and collects 16 handshakes.
  // Returns positioned in the done cycle.
  task automatic run_sched(input logic [63:0] k, input logic dec, input int stall,
                           input bit glitch, output logic [47:0] sk [16], output int n);
    int          cyc, busy_cnt, stall_left;
    bit          did_stall, prev_stalled, done_early, rdy;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rd;
    n = 0; busy_cnt = 0; stall_left = 0; did_stall = 0; prev_stalled = 0; done_early = 0;
    prev_sk = '0; prev_rd = '0;
    for (int i = 0; i < 16; i++) sk[i] = '0;
    bus.start = 1'b1; bus.key = k; bus.decrypt = dec; bus.subkey_ready = 1'b0;
    step();
    bus.start = 1'b0; bus.key = {$urandom, $urandom}; bus.decrypt = ~dec;
    chk("valid_after_start", 64'(bus.subkey_valid), 64'd1);
    chk("done_low_after_start", 64'(bus.done), 64'd0);
    cyc = 0;
    while (n < 16 && cyc < 300) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_early = 1;
      if (prev_stalled) begin
        chk("stall_subkey_stable", 64'(bus.subkey), 64'(prev_sk));
        chk("stall_round_stable", 64'(bus.round), 64'(prev_rd));
      end
      if (stall == 0) rdy = 1'b1;
      else begin
        if (n == 6 && !did_stall) begin stall_left = 10; did_stall = 1; end
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else rdy = 1'($urandom_range(0, 1));
      end
      bus.subkey_ready = rdy;
      bus.start = glitch && bus.subkey_valid && (bus.round == 4'd5 || (bus.round == 4'd15 && rdy));
      if (bus.start) begin bus.key = ~k; bus.decrypt = ~dec; end
      if (bus.subkey_valid && rdy) begin
        chk("round_seq", 64'(bus.round), 64'(n));
        sk[n] = bus.subkey;
        n++;
      end
      prev_stalled = bus.subkey_valid && !rdy;
      prev_sk = bus.subkey;
      prev_rd = bus.round;
      step();
      cyc++;
    end
    bus.start = 1'b0; bus.subkey_ready = 1'b0;
    if (cyc >= 300) begin
      failures++;
      $display("FAIL handshake_budget actual=%0d required=16", n);
    end
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("busy_low_done", 64'(bus.busy), 64'd0);
    chk("subkey_zero_idle", 64'(bus.subkey), 64'd0);
    chk("round_zero_idle", 64'(bus.round), 64'd0);
    chk("no_early_done", 64'(done_early), 64'd0);
    if (stall == 0) chk("busy_cycles", 64'(busy_cnt), 64'd16);
  endtask

  task automatic check_sched(input logic [63:0] k, input logic dec, input string tag);
    for (int p = 0; p < 16; p++)
      chk($sformatf("%s_model_p%0d", tag, p), 64'(got[p]), 64'(model_subkey(k, dec, p)));
  endtask

  initial begin
    logic [63:0] kk;
    int          cyc;
    kk = 64'h133457799BBCDFF1;
    vecs[0] = '{kk, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0, 1'b0};
    vecs[1] = '{kk, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 0, 1'b0};
    vecs[2] = '{64'h0000000000000000, 1'b0, 48'h0, 48'h0, 0, 1'b0};
    vecs[3] = '{64'h0101010101010101, 1'b0, 48'h0, 48'h0, 0, 1'b0};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 0, 1'b0};
    vecs[5] = '{kk, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 1, 1'b0};
    vecs[6] = '{kk, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 1, 1'b0};
    vecs[7] = '{kk, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0, 1'b1};

    bus.start = 1'b0; bus.decrypt = 1'b0; bus.key = '0; bus.subkey_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_subkey", 64'(bus.subkey), 64'd0);
    chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_round", 64'(bus.round), 64'd0);
    chk("rst_state", 64'(bus.state_dbg), 64'd0);
    rst = 1'b0;
    step();

    // Back-to-back: each run after the first starts in the previous done cycle.
    for (int v = 0; v < 8; v++) begin
      run_sched(vecs[v].key, vecs[v].dec, vecs[v].stall, vecs[v].glitch, got, n_got);
      chk($sformatf("v%0d_count", v), 64'(n_got), 64'd16);
      chk($sformatf("v%0d_first", v), 64'(got[0]), 64'(vecs[v].first));
      chk($sformatf("v%0d_last", v), 64'(got[15]), 64'(vecs[v].last));
      check_sched(vecs[v].key, vecs[v].dec, $sformatf("v%0d", v));
      if (v == 0) for (int p = 0; p < 16; p++) enc_ref[p] = got[p];
      if (v == 1)
        for (int p = 0; p < 16; p++)
          chk($sformatf("dec_reverse_p%0d", p), 64'(got[p]), 64'(enc_ref[15 - p]));
    end
    step();
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    // Reset while presenting position 7.
    bus.start = 1'b1; bus.key = kk; bus.decrypt = 1'b0; bus.subkey_ready = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.round != 4'd7 && cyc < 30) begin step(); cyc++; end
    chk("reached_round7", 64'(bus.round), 64'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.subkey_ready = 1'b0;
    chk("midrst_subkey", 64'(bus.subkey), 64'd0);
    chk("midrst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_round", 64'(bus.round), 64'd0);
    chk("midrst_state", 64'(bus.state_dbg), 64'd0);
    step();
    chk("midrst_no_done", 64'(bus.done), 64'd0);
    chk("midrst_idle", 64'(bus.busy), 64'd0);
    run_sched(kk, 1'b0, 0, 1'b0, got, n_got);
    chk("post_rst_count", 64'(n_got), 64'd16);
    chk("post_rst_first", 64'(got[0]), 64'h1B02EFFC7072);
    chk("post_rst_last", 64'(got[15]), 64'hCB3D8B0E17F5);
    for (int p = 0; p < 16; p++)
      chk($sformatf("post_rst_p%0d", p), 64'(got[p]), 64'(enc_ref[p]));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
